// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1432,
    parameter int TIMEOUT_CYCLES = 214773
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_RTS     = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;

    localparam logic [17:0] INHIBIT_LAST = 18'(INHIBIT_CYCLES - 1);
    localparam logic [17:0] TIMEOUT_LAST = 18'(TIMEOUT_CYCLES - 1);
    localparam logic [17:0] CNT_MAX      = 18'h3ffff;

    logic [1:0]  clk_sync_q, data_sync_q;
    logic        clk_prev_q;
    logic [2:0]  state_q, state_d;
    logic [17:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  tx_q, tx_d;
    logic        parity_q, parity_d;
    logic        data_oe_q, data_oe_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic clk_s, data_s, fall, watched, timeout;

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign fall    = clk_prev_q & ~clk_s;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 18'd1;
    assign watched = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT);
    assign timeout = watched && (cnt_q >= TIMEOUT_LAST);

    // Pin synchronizers and clock history; idle-high reset avoids a false fall
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_s;
        end
    end

    // Transaction sequencing: inhibit, request-to-send, shift, acknowledge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        tx_d      = tx_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        if (timeout) begin
            // Watchdog has priority over any edge arriving in the same cycle
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
            cnt_d     = 18'd0;
            error_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_oe_d = 1'b0;
                    if (tx_start) begin
                        tx_d     = tx_data;
                        parity_d = ~^tx_data;
                        cnt_d    = 18'd0;
                        state_d  = ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    data_oe_d = 1'b0;
                    cnt_d     = cnt_inc;
                    if (cnt_q >= INHIBIT_LAST) begin
                        data_oe_d = 1'b1;
                        state_d   = ST_RTS;
                    end
                end
                ST_RTS: begin
                    cnt_d    = 18'd0;
                    bitcnt_d = 4'd0;
                    state_d  = ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q < 4'd8) begin
                            data_oe_d = ~tx_q[bitcnt_q[2:0]];
                        end else if (bitcnt_q == 4'd8) begin
                            data_oe_d = ~parity_q;
                        end else begin
                            data_oe_d = 1'b0;
                            state_d   = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        if (!data_s) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 18'd0;
                            error_d = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_inc;
                    if (clk_s && data_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = 18'd0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 18'd0;
            bitcnt_q  <= 4'd0;
            tx_q      <= 8'd0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            tx_q      <= tx_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign rx_inhibit  = busy;
    assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx with behavioural keyboard
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 3000;
    localparam int H   = 10;
    localparam int BIG = 32'h3fffffff;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_start = 1'b0;
    logic       busy, done, error, rx_inhibit;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       kbd_clk = 1'b1;
    logic       kbd_data = 1'b1;

    assign ps2_clk_in  = kbd_clk & ~ps2_clk_oe;
    assign ps2_data_in = kbd_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .done(done), .error(error), .rx_inhibit(rx_inhibit),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: transaction accepted in window m_a, ends (busy low) in window m_end
    bit          m_active = 1'b0;
    int          m_a = 0;
    int          m_end = BIG;
    int          m_kind = 0;
    logic [10:0] m_frame = 11'd0;
    int          falls[16];
    int          nf = 0;

    int  n_vec = 0, n_bad = 0;
    bit  chk_en = 1'b0;
    int  n_done = 0, n_err = 0, last_err = 0;
    int  inh_run = 0, last_inh = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic exp_data_oe(input int c, input bit in_tx);
        int k;
        if (!in_tx || c <= m_a + INH) return 1'b0;
        k = 0;
        for (int i = 0; i < nf; i++) if (falls[i] + 3 <= c) k++;
        if (k >= 10) return 1'b0;
        return ~m_frame[k];
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int c = cyc;
            automatic bit in_tx = m_active && (c >= m_a + 1) && (c < m_end);
            check("busy", 32'(busy), 32'(in_tx));
            check("rx_inhibit", 32'(rx_inhibit), 32'(in_tx));
            check("clk_oe", 32'(ps2_clk_oe), 32'(in_tx && (c <= m_a + 1 + INH)));
            check("data_oe", 32'(ps2_data_oe), 32'(exp_data_oe(c, in_tx)));
            check("done", 32'(done), 32'(m_active && c == m_end && m_kind == 1));
            check("error", 32'(error), 32'(m_active && c == m_end && m_kind == 2));
            if (done === 1'b1) n_done++;
            if (error === 1'b1) begin n_err++; last_err = c; end
            if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_run++;
            else if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && inh_run > 0) begin
                last_inh = inh_run; inh_run = 0;
            end else inh_run = 0;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        m_a      = cyc;
        m_frame  = {1'b1, ~^b, b, 1'b0};
        nf       = 0;
        m_end    = BIG;
        m_kind   = 0;
        m_active = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Keyboard: waits for request-to-send, clocks nclk bits, samples on rising edges
    task automatic kbd_run(input int nclk, input bit ack_low, output logic [9:0] cap);
        int w;
        int f11;
        cap = 10'd0;
        w = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < INH + 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= INH + 100) begin
            n_vec++; n_bad++;
            $display("FAIL rts_detect cycle %0d: got no request expected request", cyc);
            return;
        end
        repeat (4) @(negedge clk);
        for (int i = 1; i <= nclk; i++) begin
            kbd_clk = 1'b0;
            falls[nf] = cyc;
            nf++;
            if (i == 11) begin
                f11 = cyc;
                if (ack_low) begin
                    m_end  = ((f11 + 3 > f11 + H + 4) ? f11 + 3 : f11 + H + 4) + 1;
                    m_kind = 1;
                end else begin
                    m_end  = f11 + 3;
                    m_kind = 2;
                end
            end
            repeat (H) @(negedge clk);
            if (i <= 10) cap[i-1] = ps2_data_in;
            kbd_clk = 1'b1;
            if (i == 10 && ack_low) kbd_data = 1'b0;
            if (i == 11) begin
                repeat (2) @(negedge clk);
                kbd_data = 1'b1;
                repeat (H - 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic wait_end();
        int g = 0;
        while (cyc <= m_end && g < TO + INH + 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= TO + INH + 500) begin
            n_vec++; n_bad++;
            $display("FAIL end_timeout cycle %0d: got busy expected end", cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [9:0] cap;
        int r, d0, e0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("reset_pulses", 32'({done, error}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED with acknowledging keyboard
        d0 = n_done;
        send(8'hED);
        kbd_run(11, 1'b1, cap);
        wait_end();
        check("ed_byte", 32'(cap[7:0]), 32'h000000ED);
        check("ed_parity", 32'(cap[8]), 32'd1);
        check("ed_stop", 32'(cap[9]), 32'd1);
        check("ed_done_count", 32'(n_done - d0), 32'd1);
        check("inhibit_len", 32'(last_inh), 32'(INH));

        // 0xF4 and 0x00 parity cases
        send(8'hF4);
        kbd_run(11, 1'b1, cap);
        wait_end();
        check("f4_byte", 32'(cap[7:0]), 32'h000000F4);
        check("f4_parity", 32'(cap[8]), 32'd0);
        send(8'h00);
        kbd_run(11, 1'b1, cap);
        wait_end();
        check("00_byte", 32'(cap[7:0]), 32'd0);
        check("00_parity", 32'(cap[8]), 32'd1);

        // Keyboard never clocks: watchdog fires
        d0 = n_done;
        e0 = n_err;
        send(8'hA5);
        m_end  = m_a + 2 + INH + TO;
        m_kind = 2;
        wait_end();
        check("to_latency", 32'(last_err - (m_a + 2 + INH)), 32'(TO));
        check("to_err_count", 32'(n_err - e0), 32'd1);
        check("to_no_done", 32'(n_done - d0), 32'd0);

        // All clocks but no ACK
        e0 = n_err;
        send(8'h3C);
        kbd_run(11, 1'b0, cap);
        wait_end();
        check("noack_byte", 32'(cap[7:0]), 32'h0000003C);
        check("noack_err_time", 32'(last_err - falls[10]), 32'd3);
        check("noack_err_count", 32'(n_err - e0), 32'd1);

        // Repeated tx_start while busy is ignored
        send(8'h55);
        repeat (4) @(negedge clk);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        kbd_run(11, 1'b1, cap);
        wait_end();
        check("rep_byte", 32'(cap[7:0]), 32'h00000055);

        // Reset in the middle of the shift phase
        d0 = n_done;
        e0 = n_err;
        send(8'h66);
        kbd_run(4, 1'b1, cap);
        r = cyc;
        reset  = 1'b1;
        m_end  = r + 1;
        m_kind = 0;
        @(negedge clk);
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
